hdmi_tmds_channel_encoder: RTL and testbench



---
 rtl/hdmi_tmds_pkg.sv | 47 ++++
 rtl/hdmi_tmds_channel_encoder_terc4_lut.sv | 10 +
 rtl/num_of_ones.sv | 12 +
 rtl/hdmi_tmds_channel_encoder.sv | 157 +++++++++++++++
 tb/tb_hdmi_tmds_channel_encoder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/hdmi_tmds_pkg.sv
// hdmi_tmds_pkg: mode encodings, CONTROL/TERC4 code tables and guard-band characters
// shared by the HDMI TMDS channel encoder and its sub-modules.
package hdmi_tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CONTROL      = 3'd0,
        MODE_VIDEO        = 3'd1,
        MODE_ISLAND       = 3'd2,
        MODE_VIDEO_GUARD  = 3'd3,
        MODE_ISLAND_GUARD = 3'd4
    } tmds_mode_e;

    localparam logic [9:0] GUARD_LANE02 = 10'b1011001100;
    localparam logic [9:0] GUARD_LANE1  = 10'b0100110011;
    localparam logic [9:0] CTL_IDLE     = 10'b1101010100;

    function automatic logic [9:0] control_code(input logic [1:0] c);
        case (c)
            2'b00:   control_code = 10'b1101010100;
            2'b01:   control_code = 10'b0010101011;
            2'b10:   control_code = 10'b0101010100;
            default: control_code = 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] d);
        case (d)
            4'h0:    terc4_code = 10'b1010011100;
            4'h1:    terc4_code = 10'b1001100011;
            4'h2:    terc4_code = 10'b1011100100;
            4'h3:    terc4_code = 10'b1011100010;
            4'h4:    terc4_code = 10'b0101110001;
            4'h5:    terc4_code = 10'b0100011110;
            4'h6:    terc4_code = 10'b0110001110;
            4'h7:    terc4_code = 10'b0100111100;
            4'h8:    terc4_code = 10'b1011001100;
            4'h9:    terc4_code = 10'b0100111001;
            4'hA:    terc4_code = 10'b0110011100;
            4'hB:    terc4_code = 10'b1011000110;
            4'hC:    terc4_code = 10'b1010001110;
            4'hD:    terc4_code = 10'b1001110001;
            4'hE:    terc4_code = 10'b0101100011;
            default: terc4_code = 10'b1011000011;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_tmds_channel_encoder_terc4_lut.sv
// tmds_terc4_lut: combinational TERC4 nibble to 10-bit character lookup.
// Ports: i_nibble [3:0] data-island nibble, o_char [9:0] TERC4 character (bit 0 sent first).
module tmds_terc4_lut
    import hdmi_tmds_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [9:0] o_char
);
    assign o_char = terc4_code(i_nibble);
endmodule

// File: rtl/num_of_ones.sv
// num_of_ones: population count of an 8-bit word.
// Ports: i_data [7:0] word to count, o_count [3:0] number of set bits (0..8).
module num_of_ones (
    input  logic [7:0] i_data,
    output logic [3:0] o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < 8; i++)
            o_count = o_count + {3'b000, i_data[i]};
    end
endmodule

// File: rtl/hdmi_tmds_channel_encoder.sv
// hdmi_tmds_channel_encoder: pipelined per-lane TMDS encoder (video 8b/10b, control,
// TERC4 data island, video/island guard bands).
// Ports: pixelClock clock; resetN sync active-low reset; mode [2:0] period select;
// videoData [7:0] pixel byte; controlBus [1:0] {C1,C0} / {VSYNC,HSYNC};
// auxData [3:0] TERC4 nibble; tmdsCharacter [9:0] registered character;
// disparity [4:0] signed running disparity after the current character.
module hdmi_tmds_channel_encoder
    import hdmi_tmds_pkg::*;
#(
    parameter int CHANNEL_NUMBER  = 0,
    parameter bit REGISTER_INPUTS = 1'b0
) (
    input  logic              pixelClock,
    input  logic              resetN,
    input  logic [2:0]        mode,
    input  logic [7:0]        videoData,
    input  logic [1:0]        controlBus,
    input  logic [3:0]        auxData,
    output logic [9:0]        tmdsCharacter,
    output logic signed [4:0] disparity
);

    if (CHANNEL_NUMBER < 0 || CHANNEL_NUMBER > 2) begin : g_bad_channel
        $error("hdmi_tmds_channel_encoder: CHANNEL_NUMBER must be 0, 1 or 2");
    end

    logic [2:0] w_mode;
    logic [7:0] w_data;
    logic [1:0] w_ctl;
    logic [3:0] w_aux;

    if (REGISTER_INPUTS) begin : g_in_reg
        logic [2:0] r_in_mode;
        logic [7:0] r_in_data;
        logic [1:0] r_in_ctl;
        logic [3:0] r_in_aux;
        always_ff @(posedge pixelClock) begin
            if (!resetN) begin
                r_in_mode <= MODE_CONTROL;
                r_in_data <= '0;
                r_in_ctl  <= '0;
                r_in_aux  <= '0;
            end else begin
                r_in_mode <= mode;
                r_in_data <= videoData;
                r_in_ctl  <= controlBus;
                r_in_aux  <= auxData;
            end
        end
        assign w_mode = r_in_mode;
        assign w_data = r_in_data;
        assign w_ctl  = r_in_ctl;
        assign w_aux  = r_in_aux;
    end else begin : g_in_direct
        assign w_mode = mode;
        assign w_data = videoData;
        assign w_ctl  = controlBus;
        assign w_aux  = auxData;
    end

    // Stage 1: transition-minimising q_m for video, final character for every other mode.
    logic [3:0] w_n1_data;
    logic [3:0] w_n1_qm;
    logic       w_use_xnor;
    logic [8:0] w_qm;
    logic [3:0] w_terc_in;
    logic [9:0] w_terc4;
    logic [9:0] w_video_guard;
    logic [9:0] w_island_guard;
    logic [9:0] w_aux_char;

    num_of_ones u_n1_data (.i_data(w_data),     .o_count(w_n1_data));
    num_of_ones u_n1_qm   (.i_data(w_qm[7:0]),  .o_count(w_n1_qm));

    assign w_use_xnor = (w_n1_data > 4'd4) || (w_n1_data == 4'd4 && !w_data[0]);

    always_comb begin
        logic [7:0] v_chain;
        v_chain    = '0;
        v_chain[0] = w_data[0];
        for (int i = 1; i < 8; i++)
            v_chain[i] = w_use_xnor ? ~(w_data[i] ^ v_chain[i-1]) : (w_data[i] ^ v_chain[i-1]);
        w_qm = {~w_use_xnor, v_chain};
    end

    // Lane 0 carries {VSYNC,HSYNC} as TERC4 during the island guard band.
    assign w_terc_in = (w_mode == MODE_ISLAND_GUARD) ? {2'b11, w_ctl} : w_aux;

    tmds_terc4_lut u_terc4 (.i_nibble(w_terc_in), .o_char(w_terc4));

    assign w_video_guard  = (CHANNEL_NUMBER == 1) ? GUARD_LANE1 : GUARD_LANE02;
    assign w_island_guard = (CHANNEL_NUMBER == 0) ? w_terc4 : GUARD_LANE1;
    assign w_aux_char     = (w_mode == MODE_ISLAND)       ? w_terc4 :
                            (w_mode == MODE_VIDEO_GUARD)  ? w_video_guard :
                            (w_mode == MODE_ISLAND_GUARD) ? w_island_guard :
                                                            control_code(w_ctl);

    logic       r_s1_video;
    logic [8:0] r_s1_qm;
    logic [3:0] r_s1_n1;
    logic [9:0] r_s1_char;

    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            r_s1_video <= 1'b0;
            r_s1_qm    <= '0;
            r_s1_n1    <= '0;
            r_s1_char  <= CTL_IDLE;
        end else begin
            r_s1_video <= (w_mode == MODE_VIDEO);
            r_s1_qm    <= w_qm;
            r_s1_n1    <= w_n1_qm;
            r_s1_char  <= w_aux_char;
        end
    end

    // Stage 2: DC balancing. w_diff is N1-N0 = 2*N1-8; 6-bit intermediates avoid overflow.
    logic signed [4:0] r_cnt;
    logic [9:0]        r_char;
    logic signed [5:0] w_diff;
    logic signed [5:0] w_cnt_ext;
    logic signed [5:0] w_q8x2;
    logic signed [5:0] w_nq8x2;
    logic signed [5:0] w_cnt_next;
    logic              w_case_a;
    logic              w_case_b;
    logic [9:0]        w_vid_char;

    assign w_diff    = $signed({1'b0, r_s1_n1, 1'b0}) - 6'sd8;
    assign w_cnt_ext = {r_cnt[4], r_cnt};
    assign w_q8x2    = $signed({4'b0000, r_s1_qm[8], 1'b0});
    assign w_nq8x2   = $signed({4'b0000, ~r_s1_qm[8], 1'b0});
    assign w_case_a  = (r_cnt == 5'sd0) || (w_diff == 6'sd0);
    assign w_case_b  = (r_cnt > 5'sd0 && w_diff > 6'sd0) || (r_cnt < 5'sd0 && w_diff < 6'sd0);

    assign w_cnt_next = w_case_a ? (r_s1_qm[8] ? w_cnt_ext + w_diff : w_cnt_ext - w_diff) :
                        w_case_b ? w_cnt_ext + w_q8x2 - w_diff :
                                   w_cnt_ext + w_diff - w_nq8x2;

    assign w_vid_char = w_case_a ? {~r_s1_qm[8], r_s1_qm[8], r_s1_qm[8] ? r_s1_qm[7:0] : ~r_s1_qm[7:0]} :
                        w_case_b ? {1'b1, r_s1_qm[8], ~r_s1_qm[7:0]} :
                                   {1'b0, r_s1_qm[8], r_s1_qm[7:0]};

    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            r_cnt  <= '0;
            r_char <= CTL_IDLE;
        end else begin
            r_cnt  <= r_s1_video ? w_cnt_next[4:0] : 5'sd0;
            r_char <= r_s1_video ? w_vid_char : r_s1_char;
        end
    end

    assign tmdsCharacter = r_char;
    assign disparity     = r_cnt;

endmodule

// File: tb/tb_hdmi_tmds_channel_encoder.sv
// tb_hdmi_tmds_channel_encoder: directed + randomized checks of three lanes (and one
// input-registered lane) against a table/arithmetic reference model.
module tb_hdmi_tmds_channel_encoder;

    localparam int MAXS = 10400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] mode;
    logic [7:0] vdata;
    logic [1:0] cbus;
    logic [3:0] aux;

    logic [9:0]        ch0, ch1, ch2, ch1r;
    logic signed [4:0] d0, d1, d2, d1r;

    hdmi_tmds_channel_encoder #(.CHANNEL_NUMBER(0), .REGISTER_INPUTS(1'b0)) u_l0 (
        .pixelClock(clk), .resetN(rst_n), .mode(mode), .videoData(vdata),
        .controlBus(cbus), .auxData(aux), .tmdsCharacter(ch0), .disparity(d0));
    hdmi_tmds_channel_encoder #(.CHANNEL_NUMBER(1), .REGISTER_INPUTS(1'b0)) u_l1 (
        .pixelClock(clk), .resetN(rst_n), .mode(mode), .videoData(vdata),
        .controlBus(cbus), .auxData(aux), .tmdsCharacter(ch1), .disparity(d1));
    hdmi_tmds_channel_encoder #(.CHANNEL_NUMBER(2), .REGISTER_INPUTS(1'b0)) u_l2 (
        .pixelClock(clk), .resetN(rst_n), .mode(mode), .videoData(vdata),
        .controlBus(cbus), .auxData(aux), .tmdsCharacter(ch2), .disparity(d2));
    hdmi_tmds_channel_encoder #(.CHANNEL_NUMBER(1), .REGISTER_INPUTS(1'b1)) u_l1r (
        .pixelClock(clk), .resetN(rst_n), .mode(mode), .videoData(vdata),
        .controlBus(cbus), .auxData(aux), .tmdsCharacter(ch1r), .disparity(d1r));

    logic [9:0] terc_t [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [9:0] ctl_t [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    logic [9:0] e_ch [3][MAXS];
    int         e_disp [MAXS];
    bit         e_rst [MAXS];
    int         k = 0;
    int         cnt_m = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    endtask

    // Compare one DUT output with the character that should be emerging after `lat` stages.
    task automatic chk_dut(input string tag, input int lane, input int lat,
                           input logic [9:0] oc, input logic signed [4:0] od);
        bit rs = 0;
        for (int j = 0; j < lat; j++)
            if (k - j >= 0 && e_rst[k-j]) rs = 1;
        if (rs) begin
            chk({tag, "_ch"}, {6'b0, oc}, {6'b0, ctl_t[0]});
            chk({tag, "_disp"}, 16'(od), 16'sd0);
        end else if (k - lat >= 0) begin
            chk({tag, "_ch"}, {6'b0, oc}, {6'b0, e_ch[lane][k-lat]});
            chk({tag, "_disp"}, 16'(od), 16'(e_disp[k-lat]));
        end
    endtask

    task automatic step(input logic [2:0] m, input logic [7:0] vd, input logic [1:0] cb,
                        input logic [3:0] ad, input bit rn);
        @(negedge clk);
        rst_n = rn; mode = m; vdata = vd; cbus = cb; aux = ad;
        e_rst[k] = !rn;
        if (!rn) begin
            cnt_m = 0;
            for (int l = 0; l < 3; l++) e_ch[l][k] = ctl_t[0];
        end else if (m == 3'd1) begin
            int n1, n1q, n0q;
            bit xn;
            logic [8:0] qm;
            logic [9:0] c;
            n1 = $countones(vd);
            xn = (n1 > 4) || (n1 == 4 && vd[0] == 1'b0);
            qm[0] = vd[0];
            for (int b = 1; b < 8; b++) qm[b] = xn ? ~(vd[b] ^ qm[b-1]) : (vd[b] ^ qm[b-1]);
            qm[8] = !xn;
            n1q = $countones(qm[7:0]);
            n0q = 8 - n1q;
            if (cnt_m == 0 || n1q == n0q) begin
                c = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                cnt_m += qm[8] ? (n1q - n0q) : (n0q - n1q);
            end else if ((cnt_m > 0 && n1q > n0q) || (cnt_m < 0 && n0q > n1q)) begin
                c = {1'b1, qm[8], ~qm[7:0]};
                cnt_m += 2 * int'(qm[8]) + n0q - n1q;
            end else begin
                c = {1'b0, qm[8], qm[7:0]};
                cnt_m += n1q - n0q - 2 * int'(!qm[8]);
            end
            for (int l = 0; l < 3; l++) e_ch[l][k] = c;
        end else begin
            cnt_m = 0;
            for (int l = 0; l < 3; l++)
                e_ch[l][k] = (m == 3'd2) ? terc_t[ad] :
                             (m == 3'd3) ? ((l == 1) ? 10'b0100110011 : 10'b1011001100) :
                             (m == 3'd4) ? ((l == 0) ? terc_t[{2'b11, cb}] : 10'b0100110011) :
                                           ctl_t[cb];
        end
        e_disp[k] = cnt_m;
        @(posedge clk);
        #1;
        chk_dut("lane0", 0, 1, ch0, d0);
        chk_dut("lane1", 1, 1, ch1, d1);
        chk_dut("lane2", 2, 1, ch2, d2);
        chk_dut("lane1_reg", 1, 2, ch1r, d1r);
        k++;
    endtask

    initial begin
        rst_n = 1'b0; mode = 3'd0; vdata = '0; cbus = '0; aux = '0;
        // reset held with CONTROL 10 on the bus
        for (int i = 0; i < 3; i++) begin
            step(3'd0, 8'h00, 2'b10, 4'h0, 1'b0);
            chk("rst_ch", {6'b0, ch0}, 16'sd852);
            chk("rst_disp", 16'(d0), 16'sd0);
        end
        step(3'd0, 8'h00, 2'b10, 4'h0, 1'b1);
        chk("release1", {6'b0, ch0}, {6'b0, 10'b1101010100});
        step(3'd0, 8'h00, 2'b10, 4'h0, 1'b1);
        chk("release2", {6'b0, ch0}, {6'b0, 10'b0101010100});
        // two zero pixels from cnt=0
        step(3'd1, 8'h00, 2'b00, 4'h0, 1'b1);
        step(3'd1, 8'h00, 2'b00, 4'h0, 1'b1);
        chk("vid00_a_ch", {6'b0, ch0}, {6'b0, 10'b0100000000});
        chk("vid00_a_disp", 16'(d0), -16'sd8);
        step(3'd0, 8'h00, 2'b00, 4'h0, 1'b1);
        chk("vid00_b_ch", {6'b0, ch0}, {6'b0, 10'b1111111111});
        chk("vid00_b_disp", 16'(d0), 16'sd2);
        // ISLAND nibble C: two edges on plain lane, three with input register
        step(3'd2, 8'h00, 2'b00, 4'hC, 1'b1);
        step(3'd0, 8'h00, 2'b00, 4'h0, 1'b1);
        chk("island_c_l1", {6'b0, ch1}, {6'b0, 10'b1010001110});
        step(3'd0, 8'h00, 2'b00, 4'h0, 1'b1);
        chk("island_c_l1reg", {6'b0, ch1r}, {6'b0, 10'b1010001110});
        // guard bands
        step(3'd4, 8'h00, 2'b01, 4'h0, 1'b1);
        step(3'd3, 8'h00, 2'b00, 4'h0, 1'b1);
        chk("iguard_l0", {6'b0, ch0}, {6'b0, 10'b1001110001});
        chk("iguard_l1", {6'b0, ch1}, {6'b0, 10'b0100110011});
        chk("iguard_l2", {6'b0, ch2}, {6'b0, 10'b0100110011});
        step(3'd0, 8'h00, 2'b00, 4'h0, 1'b1);
        chk("vguard_l0", {6'b0, ch0}, {6'b0, 10'b1011001100});
        chk("vguard_l1", {6'b0, ch1}, {6'b0, 10'b0100110011});
        chk("vguard_l2", {6'b0, ch2}, {6'b0, 10'b1011001100});
        // random stream, mostly video with occasional other (incl. 5..7) periods
        for (int i = 0; i < 10000; i++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 99) < 92) ? 3'd1 : 3'($urandom_range(0, 7));
            if (i == 5000) m = 3'd0;
            step(m, 8'($urandom), 2'($urandom), 4'($urandom), 1'b1);
            chk("disp_bound", 16'(d0 >= -5'sd10 && d0 <= 5'sd10), 16'sd1);
            if (i == 5001) chk("ctl_mid_disp", 16'(d0), 16'sd0);
        end
        // reset in the middle of a biased video burst
        for (int i = 0; i < 4; i++) step(3'd1, 8'hFF, 2'b00, 4'h0, 1'b1);
        step(3'd1, 8'h01, 2'b00, 4'h0, 1'b1);
        step(3'd1, 8'hFE, 2'b00, 4'h0, 1'b0);
        chk("midrst_ch", {6'b0, ch0}, {6'b0, 10'b1101010100});
        chk("midrst_disp", 16'(d0), 16'sd0);
        for (int i = 0; i < 3; i++) step(3'd0, 8'h00, 2'b11, 4'h0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
